// File: rtl/uart_comm_pkg.sv
// rtl/uart_comm_pkg.sv - shared types and constants for the uart command comm stage
package uart_comm_pkg;

    localparam int DATA_BITS = 8;
    localparam int CMD_BYTES = 3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 receiver: RX synchroniser, mid-bit sampling FSM, byte strobe
module uart_rx_core
    import uart_comm_pkg::*;
#(
    parameter int BAUD_DIV = 2083
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_byte_o,
    output logic                 rx_strobe_o,
    output logic                 rx_ferr_o
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV);

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic                 rx_fall;
    rx_state_t            state_q;
    logic [CW-1:0]        cnt_q;
    logic [2:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_sync_q;

    // Counter counts down to 1; each sample point is one load value after the previous one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_byte_o   <= '0;
            rx_strobe_o <= 1'b0;
            rx_ferr_o   <= 1'b0;
        end else begin
            rx_strobe_o <= 1'b0;
            rx_ferr_o   <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        cnt_q   <= HALF_BIT;
                        bit_q   <= '0;
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == CW'(1)) begin
                        if (rx_sync_q) begin
                            state_q <= RX_IDLE;
                        end else begin
                            cnt_q   <= FULL_BIT;
                            state_q <= RX_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CW'(1)) begin
                        shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= FULL_BIT;
                        if (bit_q == 3'(DATA_BITS - 1)) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CW'(1)) begin
                        if (rx_sync_q) begin
                            rx_byte_o   <= shift_q;
                            rx_strobe_o <= 1'b1;
                        end else begin
                            rx_ferr_o <= 1'b1;
                        end
                        state_q <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_comm.sv
// rtl/uart_cmd_comm.sv - host comm stage: 3-byte command assembler, 8N1 response TX
// Optional inter-byte gap timeout enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_comm
    import uart_comm_pkg::*;
#(
    parameter int BAUD_DIV    = 2083,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    output logic                 TX,
    output logic [23:0]          cmd,
    output logic                 cmd_rdy,
    input  logic                 clr_cmd_rdy,
    input  logic [DATA_BITS-1:0] resp_data,
    input  logic                 send_resp,
    output logic                 resp_sent
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);

    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_strobe, rx_ferr, gap_hit;

    uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (RX),
        .rx_byte_o  (rx_byte),
        .rx_strobe_o(rx_strobe),
        .rx_ferr_o  (rx_ferr)
    );

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] shadow_q, shadow_d;
    logic [23:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;

`ifdef CMD_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYC + 1);
    logic [GW-1:0] gap_q;

    assign gap_hit = (byte_idx_q != 2'd0) && (gap_q == GW'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q <= '0;
        end else if (rx_strobe || byte_idx_q == 2'd0 || gap_hit) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_q + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign gap_hit        = 1'b0;
`endif

    // A completing command loads unless an unconsumed one is pending; a same-cycle clear lets it load.
    always_comb begin
        byte_idx_d = byte_idx_q;
        shadow_d   = shadow_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        if (rx_strobe) begin
            case (byte_idx_q)
                2'd0: begin
                    shadow_d[15:8] = rx_byte;
                    byte_idx_d     = 2'd1;
                end
                2'd1: begin
                    shadow_d[7:0] = rx_byte;
                    byte_idx_d    = 2'd2;
                end
                default: begin
                    byte_idx_d = 2'd0;
                    if (!cmd_rdy_q || clr_cmd_rdy) begin
                        cmd_d     = {shadow_q, rx_byte};
                        cmd_rdy_d = 1'b1;
                    end
                end
            endcase
        end else if (rx_ferr || gap_hit) begin
            byte_idx_d = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx_q <= 2'd0;
            shadow_q   <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
        end else begin
            byte_idx_q <= byte_idx_d;
            shadow_q   <= shadow_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

    tx_state_t            tx_state_q;
    logic [CW-1:0]        tx_cnt_q;
    logic [2:0]           tx_bit_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_q, resp_sent_q;

    // resp_sent_q is high in the first IDLE cycle, which is what blocks a coincident send_resp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b0;
        end else begin
            resp_sent_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (send_resp && !resp_sent_q) begin
                        tx_shift_q <= resp_data;
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= BIT_LAST;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == '0) begin
                        tx_q       <= tx_shift_q[0];
                        tx_cnt_q   <= BIT_LAST;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q <= BIT_LAST;
                        if (tx_bit_q == 3'(DATA_BITS - 1)) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_shift_q <= {1'b0, tx_shift_q[DATA_BITS-1:1]};
                            tx_q       <= tx_shift_q[1];
                            tx_bit_q   <= tx_bit_q + 1'b1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == '0) begin
                        resp_sent_q <= 1'b1;
                        tx_state_q  <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign TX        = tx_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_comm.sv
// tb/tb_uart_cmd_comm.sv - scoreboard bench for uart_cmd_comm (BAUD_DIV=16, TIMEOUT_CYC=400)
module tb_uart_cmd_comm;

    localparam int BD = 16;
    localparam int TO = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        TX;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp_data = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] exp_cmd_q[$];
    logic        exp_bit_q[$];

    uart_cmd_comm #(.BAUD_DIV(BD), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp_data  (resp_data),
        .send_resp  (send_resp),
        .resp_sent  (resp_sent)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop_bit;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
        if (!stop_bit) repeat (2 * BD) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [23:0] c);
        send_byte(c[23:16], 1'b1);
        send_byte(c[15:8], 1'b1);
        send_byte(c[7:0], 1'b1);
    endtask

    task automatic wait_rdy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (cmd_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (TX !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", TX); end
        n_cmp++; if (cmd !== 24'h0) begin n_err++; $display("FAIL reset_cmd: got %h expected 000000", cmd); end
        n_cmp++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); end
        n_cmp++; if (resp_sent !== 1'b0) begin n_err++; $display("FAIL reset_resp_sent: got %b expected 0", resp_sent); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_next_cmd(input string name);
        bit ok;
        logic [23:0] exp;
        wait_rdy(ok);
        exp = exp_cmd_q.pop_front();
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL %s_rdy_timeout: got cmd_rdy=%b expected 1", name, cmd_rdy);
        end else if (cmd !== exp) begin
            n_err++; $display("FAIL %s_value: got %h expected %h", name, cmd, exp);
        end
    endtask

    task automatic test_cmd();
        exp_cmd_q.push_back(24'h081234);
        send_cmd(24'h081234);
        check_next_cmd("cmd_basic");
        pulse_clr();
        n_cmp++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL clr_rdy: got %b expected 0", cmd_rdy); end
        n_cmp++; if (cmd !== 24'h081234) begin n_err++; $display("FAIL clr_cmd_hold: got %h expected 081234", cmd); end
        pulse_clr();
        n_cmp++; if (cmd_rdy !== 1'b0 || cmd !== 24'h081234) begin
            n_err++; $display("FAIL clr_idle: got rdy=%b cmd=%h expected 0/081234", cmd_rdy, cmd);
        end
    endtask

    task automatic test_tx(input logic [7:0] d, input bit busy_pulses);
        int first_sent = -1;
        int n_sent = 0;
        bit late_low = 1'b0;
        logic exp;
        exp_bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bit_q.push_back(d[i]);
        exp_bit_q.push_back(1'b1);
        resp_data = d;
        send_resp = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            send_resp = 1'b0;
            if (c == 1) begin
                n_cmp++; if (TX !== 1'b0) begin n_err++; $display("FAIL tx_start_latency: got TX=%b expected 0", TX); end
            end
            if (c >= 9 && c <= 9 + 16 * 9 && ((c - 9) % 16) == 0) begin
                exp = exp_bit_q.pop_front();
                n_cmp++; if (TX !== exp) begin n_err++; $display("FAIL tx_bit_%0d: got %b expected %b", (c - 9) / 16, TX, exp); end
            end
            if (busy_pulses && c == 50) begin
                resp_data = 8'hFF;
                send_resp = 1'b1;
            end
            if (resp_sent === 1'b1) begin
                n_sent++;
                if (first_sent < 0) first_sent = c;
                if (busy_pulses && n_sent == 1) send_resp = 1'b1;
            end
            if (c > 162 && TX !== 1'b1) late_low = 1'b1;
        end
        n_cmp++; if (first_sent - 1 != 160) begin n_err++; $display("FAIL resp_sent_latency: got %0d expected 160", first_sent - 1); end
        n_cmp++; if (n_sent != 1) begin n_err++; $display("FAIL resp_sent_count: got %0d expected 1", n_sent); end
        n_cmp++; if (late_low) begin n_err++; $display("FAIL tx_extra_frame: got extra frame expected idle high"); end
    endtask

    task automatic test_glitch();
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (3 * BD) @(negedge clk);
        n_cmp++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL glitch_rdy: got %b expected 0", cmd_rdy); end
        exp_cmd_q.push_back(24'h112233);
        send_cmd(24'h112233);
        check_next_cmd("after_glitch");
        pulse_clr();
    endtask

    task automatic test_framing();
        send_byte(8'h99, 1'b1);
        send_byte(8'h55, 1'b0);
        exp_cmd_q.push_back(24'h667788);
        send_cmd(24'h667788);
        check_next_cmd("after_ferr");
        pulse_clr();
    endtask

    task automatic test_overrun();
        bit seen = 1'b0;
        exp_cmd_q.push_back(24'h081234);
        send_cmd(24'h081234);
        check_next_cmd("overrun_first");
        send_cmd(24'h0A0000);
        repeat (4) @(negedge clk);
        n_cmp++; if (cmd !== 24'h081234 || cmd_rdy !== 1'b1) begin
            n_err++; $display("FAIL overrun_drop: got cmd=%h rdy=%b expected 081234/1", cmd, cmd_rdy);
        end
        send_byte(8'h0A, 1'b1);
        send_byte(8'h00, 1'b1);
        exp_cmd_q.push_back(24'h0A0000);
        fork
            send_byte(8'h00, 1'b1);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (dut.rx_strobe === 1'b1) begin
                        clr_cmd_rdy = 1'b1;
                        @(negedge clk);
                        clr_cmd_rdy = 1'b0;
                        seen = 1'b1;
                        break;
                    end
                end
            end
        join
        n_cmp++; if (!seen) begin n_err++; $display("FAIL clr_on_completion_timeout: got no byte strobe expected one"); end
        check_next_cmd("clr_on_completion");
        n_cmp++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL clr_on_completion_rdy: got %b expected 1", cmd_rdy); end
        pulse_clr();
    endtask

    task automatic test_gap();
        send_byte(8'h01, 1'b1);
        repeat (500) @(negedge clk);
`ifdef CMD_TIMEOUT_EN
        exp_cmd_q.push_back(24'h020304);
`else
        exp_cmd_q.push_back(24'h010203);
`endif
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        check_next_cmd("gap");
        pulse_clr();
    endtask

    task automatic test_reset_mid();
        int sent_during = 0;
        resp_data = 8'hC3;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (40) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                n_cmp++; if (TX !== 1'b1) begin n_err++; $display("FAIL midrst_tx: got %b expected 1", TX); end
                n_cmp++; if (cmd !== 24'h0 || cmd_rdy !== 1'b0) begin
                    n_err++; $display("FAIL midrst_cmd: got cmd=%h rdy=%b expected 000000/0", cmd, cmd_rdy);
                end
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    if (resp_sent === 1'b1) sent_during++;
                end
            end
        join
        n_cmp++; if (sent_during != 0) begin n_err++; $display("FAIL midrst_resp_sent: got %0d expected 0", sent_during); end
        exp_cmd_q.push_back(24'hABCDEF);
        send_cmd(24'hABCDEF);
        check_next_cmd("after_midrst");
        pulse_clr();
        test_tx(8'h3C, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_cmd();
        test_tx(8'hA5, 1'b0);
        test_glitch();
        test_framing();
        test_overrun();
        test_tx(8'h5A, 1'b1);
        test_gap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
